pulse_sync_scheduler: RTL
=========================

PULSE_SYNC_SCHEDULER -- requirements
Module: pulse_sync_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one toggle-synchronizer channel; legal range 2..16.
REQ-002 Parameter GAP_CYCLES, default 6, guard cycles after each issued pulse; legal range 1..255.
REQ-003 Parameter CNT_W, default 3, width of each per-requester pending counter.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-006 i_rst  input  1  asynchronous, active-high reset.
REQ-007 i_req  input  N_REQ  single-cycle request pulses, one bit per requester.
REQ-008 i_en  input  1  issue enable; low blocks new issues.
REQ-009 i_ovf_clr  input  1  clears all sticky overflow flags.
REQ-010 o_pulse  output  1  one-cycle pulse to the shared synchronizer channel.
REQ-011 o_id  output  $clog2(N_REQ)  requester index of the last issued pulse, held until the next issue.
REQ-012 o_busy  output  1  high in ISSUE or GUARD.
REQ-013 o_ovf  output  N_REQ  sticky per-requester pending-counter overflow flags.

Function
REQ-014 Each requester SHALL have a CNT_W-bit pending counter: +1 on i_req bit; -1 when that requester is granted in ISSUE; both in one cycle leave it unchanged.
REQ-015 Counter at max with an increment and no decrement SHALL hold at max and set its o_ovf bit.
REQ-016 o_ovf bits SHALL clear on i_ovf_clr; simultaneous set and clear on one bit -> set wins.
REQ-017 FSM states: IDLE, ISSUE, GUARD.
REQ-018 IDLE -> ISSUE when i_en=1 and any pending counter is nonzero; otherwise stay IDLE.
REQ-019 ISSUE lasts exactly one cycle: o_pulse=1, o_id latches the granted index, granted counter decrements, round-robin pointer moves to grant+1 (mod N_REQ); -> GUARD with guard counter loaded to GAP_CYCLES-1.
REQ-020 GUARD decrements the guard counter each cycle; at 0 -> ISSUE if i_en=1 and any pending nonzero, else IDLE.
REQ-021 Pulse-to-pulse spacing SHALL be at least GAP_CYCLES+1 cycles under all conditions.
REQ-022 Grant SHALL be round-robin: first nonzero counter searching upward from the pointer, wrapping past N_REQ-1 to 0.
REQ-023 Latency: i_req sampled at edge t with the FSM idle and i_en=1 -> o_pulse high in the cycle after edge t+2.
REQ-024 i_en deassertion SHALL NOT abort ISSUE or GUARD; pending counts are retained.
REQ-025 Requests arriving in any state SHALL be counted, never dropped unless saturated.
REQ-026 o_pulse and o_busy SHALL be registered outputs.

Reset
REQ-027 On i_rst: FSM=IDLE, all pending counters=0, guard counter=0, pointer=0, o_pulse=0, o_id=0, o_busy=0, o_ovf=0.
REQ-028 Reset asserted mid-ISSUE or mid-GUARD SHALL take effect immediately; no pulse is issued until at least 2 cycles after deassertion.

Structure
REQ-029 Package pulse_sync_pkg SHALL hold the FSM state enum typedef and default parameter constants.
REQ-030 Round-robin selection SHALL be the sub-module rr_arbiter (inputs: request vector, pointer; output: grant index, grant valid).

Verification
REQ-031 Reset: assert i_rst for 3 cycles with i_req=4'b1111 -> all outputs 0, counters 0 after release.
REQ-032 Single request: i_req=4'b0100 at edge t, i_en=1 -> o_pulse high in the cycle after edge t+2, o_id=2, o_busy high for 7 cycles.
REQ-033 Fairness: i_req=4'b1111 for one cycle -> 4 pulses, o_id 0,1,2,3, exactly 7 cycles apart.
REQ-034 Saturation: i_en=0, 9 pulses on i_req[1] -> o_ovf=4'b0010; then i_en=1 -> exactly 7 pulses, all o_id=1.
REQ-035 Enable drop: deassert i_en during GUARD with 2 pending -> GUARD completes, IDLE, no pulse; re-enable -> next pulse 2 cycles later.
REQ-036 Clear race: i_ovf_clr in the same cycle as a saturating request on requester 3 -> o_ovf[3] stays 1.

Source files
------------

// File: rtl/pulse_sync_pkg.sv
// rtl/pulse_sync_pkg.sv - shared types and default parameters for the pulse sync scheduler
// Holds the scheduler FSM state type and the default parameter values
// used by the interface, the arbiter and the top.
package pulse_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_GAP_CYCLES = 6;
    localparam int DEF_CNT_W      = 3;

    // Wide enough for the largest legal guard length (255).
    localparam int GUARD_W = 8;

endpackage

// File: rtl/pulse_sync_scheduler_if.sv
// rtl/pulse_sync_scheduler_if.sv - request/issue bundle between requesters and the pulse sync scheduler
// Signals:
//   i_req     - single-cycle request pulses, one bit per requester
//   i_en      - issue enable
//   i_ovf_clr - clears all sticky overflow flags
//   o_pulse   - one-cycle pulse to the shared synchronizer channel
//   o_id      - requester index of the last issued pulse
//   o_busy    - scheduler is issuing or guarding
//   o_ovf     - sticky per-requester overflow flags
// master drives the requests, slave is the scheduler.
interface pulse_sync_scheduler_if
    import pulse_sync_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0] i_req;
    logic             i_en;
    logic             i_ovf_clr;
    logic             o_pulse;
    logic [ID_W-1:0]  o_id;
    logic             o_busy;
    logic [N_REQ-1:0] o_ovf;

    modport master (
        output i_req, i_en, i_ovf_clr,
        input  o_pulse, o_id, o_busy, o_ovf
    );

    modport slave (
        input  i_req, i_en, i_ovf_clr,
        output o_pulse, o_id, o_busy, o_ovf
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin selector over a request vector
// Ports:
//   req_vec   - one bit per requester with work pending
//   ptr       - requester index the search starts from
//   grant_idx - first requesting index at or above ptr, wrapping to 0
//   grant_vld - any bit of req_vec set
module rr_arbiter
    import pulse_sync_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]         req_vec,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     grant_vld
);
    localparam int ID_W = $clog2(N_REQ);

    // One extra bit so ptr + offset cannot wrap before the explicit modulo.
    logic [ID_W:0] k;

    // Walk offsets from farthest to nearest; the last hit (smallest offset
    // from ptr) wins, which gives the round-robin order.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        k         = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            k = {1'b0, ptr} + (ID_W + 1)'(off);
            if (k >= (ID_W + 1)'(N_REQ)) begin
                k = k - (ID_W + 1)'(N_REQ);
            end
            if (req_vec[k[ID_W-1:0]]) begin
                grant_idx = k[ID_W-1:0];
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_sync_scheduler.sv
// rtl/pulse_sync_scheduler.sv - round-robin scheduler feeding one shared pulse synchronizer channel
// Ports:
//   i_clk - sole clock, rising edge
//   i_rst - asynchronous active-high reset
//   bus   - slave side of pulse_sync_scheduler_if: requests, enable and
//           overflow clear in; pulse, id, busy and sticky overflow out
module pulse_sync_scheduler
    import pulse_sync_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    pulse_sync_scheduler_if.slave bus
);
    localparam int                  ID_W       = $clog2(N_REQ);
    localparam logic [CNT_W-1:0]    CNT_MAX    = '1;
    localparam logic [GUARD_W-1:0]  GUARD_LOAD = GUARD_W'(GAP_CYCLES - 1);

    state_t                        state;
    state_t                        state_nxt;
    logic [N_REQ-1:0][CNT_W-1:0]   pend;
    logic [N_REQ-1:0]              pend_nz;
    logic [N_REQ-1:0]              dec_vec;
    logic [N_REQ-1:0]              ovf_set;
    logic [ID_W-1:0]               rr_ptr;
    logic [ID_W-1:0]               grant_idx;
    logic                          grant_vld;
    logic [GUARD_W-1:0]            guard_cnt;
    logic                          any_pend;
    logic                          issue;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req_vec   (pend_nz),
        .ptr       (rr_ptr),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign any_pend = |pend_nz;
    assign issue    = (state == ST_ISSUE) && grant_vld;

    always_comb begin
        pend_nz = '0;
        ovf_set = '0;
        dec_vec = issue ? (N_REQ'(1) << grant_idx) : '0;
        for (int i = 0; i < N_REQ; i++) begin
            pend_nz[i] = (pend[i] != '0);
            // Only a net increment can overflow; a same-cycle grant absorbs it.
            ovf_set[i] = bus.i_req[i] && !dec_vec[i] && (pend[i] == CNT_MAX);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.i_req[i] && !dec_vec[i]) begin
                    if (pend[i] != CNT_MAX) begin
                        pend[i] <= pend[i] + 1'b1;
                    end
                end else if (dec_vec[i] && !bus.i_req[i]) begin
                    pend[i] <= pend[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // i_en only gates the start of a new issue; ISSUE and GUARD always run out.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.i_en && any_pend) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_GUARD;
            end
            ST_GUARD: begin
                if (guard_cnt == '0) begin
                    state_nxt = (bus.i_en && any_pend) ? ST_ISSUE : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            guard_cnt <= '0;
            rr_ptr    <= '0;
        end else if (issue) begin
            guard_cnt <= GUARD_LOAD;
            rr_ptr    <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if ((state == ST_GUARD) && (guard_cnt != '0)) begin
            guard_cnt <= guard_cnt - 1'b1;
        end
    end

    // Outputs are registered, so they trail the FSM state by one cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_pulse <= 1'b0;
            bus.o_busy  <= 1'b0;
            bus.o_id    <= '0;
            bus.o_ovf   <= '0;
        end else begin
            bus.o_pulse <= issue;
            bus.o_busy  <= (state != ST_IDLE);
            if (issue) begin
                bus.o_id <= grant_idx;
            end
            // Set wins over a simultaneous clear.
            bus.o_ovf <= (bus.o_ovf & ~{N_REQ{bus.i_ovf_clr}}) | ovf_set;
        end
    end

endmodule
